alu_md_sequencer: RTL and testbench

- Iterative RV32M multiply/divide controller for stage 2.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU without a dedicated multiplier or divider.
- Takes the shared stage-2 ALU through an operand/op override port and drives one ALU_ADD or ALU_SUB per cycle, holding partial products and remainders in local registers.
- Stalls the pipeline from acceptance until its single-cycle response.

---
 rtl/alu_md_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_md_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_sequencer.sv
// alu_md_sequencer: iterative RV32M multiply/divide engine that borrows the shared
// stage-2 ALU for one add/subtract per cycle while the pipeline is stalled.
`ifndef ALU_ADD
`define ALU_ADD    4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB    4'd1
`endif
`ifndef ALU_COPY_B
`define ALU_COPY_B 4'd2
`endif
`ifndef ALU_XXX
`define ALU_XXX    4'hf
`endif

module alu_md_sequencer #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            alu_grant,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_out
);

  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, ITER, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      f3;
  logic [XLEN-1:0] hi, lo, mcand;  // {hi,lo} = product, or {remainder,quotient}
  logic [4:0]      cnt;
  logic            neg_res;

  logic            signed_a, signed_b, take, carry, hi_fix;
  logic [XLEN-1:0] r_sh, res_sel;

  function automatic logic neg_rule(input logic [2:0] f, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    case (f)
      3'b000, 3'b001: return a[XLEN-1] ^ b[XLEN-1];
      3'b010, 3'b110: return a[XLEN-1];
      3'b100:         return (a[XLEN-1] ^ b[XLEN-1]) && (b != '0);
      default:        return 1'b0;
    endcase
  endfunction

  assign signed_a = !((f3 == 3'b011) || (f3 == 3'b101) || (f3 == 3'b111));
  assign signed_b = signed_a && (f3 != 3'b010);
  assign r_sh     = {hi[XLEN-2:0], lo[XLEN-1]};
  // the dropped MSB means the shifted remainder already exceeds any divisor
  assign take     = hi[XLEN-1] || (r_sh >= mcand);
  assign carry    = alu_out < hi;
  assign res_sel  = ((f3 == 3'b000) || (f3[2:1] == 2'b10)) ? lo : hi;
  assign hi_fix   = (f3 == 3'b001) || (f3 == 3'b010);

  always_comb begin
    alu_grant = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = `ALU_XXX;
    case (state)
      NEG_A: begin
        alu_grant = 1'b1;
        alu_op    = `ALU_SUB;
        alu_b     = lo;
      end
      NEG_B: begin
        alu_grant = 1'b1;
        alu_op    = `ALU_SUB;
        alu_b     = mcand;
      end
      ITER: begin
        alu_grant = 1'b1;
        alu_b     = mcand;
        if (f3[2]) begin
          alu_op = `ALU_SUB;
          alu_a  = r_sh;
        end else begin
          alu_op = `ALU_ADD;
          alu_a  = hi;
        end
      end
      FIX: begin
        alu_grant = 1'b1;
        if (!neg_res) begin
          alu_op = `ALU_COPY_B;
          alu_b  = res_sel;
        end else if (hi_fix) begin
          // two's-complement negate of the 64-bit product, high word only
          alu_op = `ALU_ADD;
          alu_a  = ~hi;
          alu_b  = XLEN'(lo == '0);
        end else begin
          alu_op = `ALU_SUB;
          alu_b  = res_sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      stall      <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      f3         <= '0;
      hi         <= '0;
      lo         <= '0;
      mcand      <= '0;
      cnt        <= '0;
      neg_res    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (kill) begin
        state     <= IDLE;
        req_ready <= 1'b1;
        stall     <= 1'b0;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            f3        <= req_funct3;
            lo        <= req_a;
            mcand     <= req_b;
            hi        <= '0;
            neg_res   <= neg_rule(req_funct3, req_a, req_b);
            state     <= NEG_A;
            req_ready <= 1'b0;
            stall     <= 1'b1;
          end
          NEG_A: begin
            if (signed_a && lo[XLEN-1]) lo <= alu_out;
            state <= NEG_B;
          end
          NEG_B: begin
            if (signed_b && mcand[XLEN-1]) mcand <= alu_out;
            cnt   <= '0;
            state <= ITER;
          end
          ITER: begin
            if (f3[2]) begin
              if (take) begin
                hi <= alu_out;
                lo <= {lo[XLEN-2:0], 1'b1};
              end else begin
                hi <= r_sh;
                lo <= {lo[XLEN-2:0], 1'b0};
              end
            end else if (lo[0]) begin
              hi <= {carry, alu_out[XLEN-1:1]};
              lo <= {alu_out[0], lo[XLEN-1:1]};
            end else begin
              hi <= {1'b0, hi[XLEN-1:1]};
              lo <= {hi[0], lo[XLEN-1:1]};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'(ITERS - 1)) state <= FIX;
          end
          FIX: begin
            resp_data  <= alu_out;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
          DONE: begin
            state     <= IDLE;
            req_ready <= 1'b1;
            stall     <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_md_sequencer.sv
// tb_alu_md_sequencer: drives alu_md_sequencer with a behavioural ALU and checks
// results against plain 64-bit arithmetic.
`ifndef ALU_ADD
`define ALU_ADD    4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB    4'd1
`endif
`ifndef ALU_COPY_B
`define ALU_COPY_B 4'd2
`endif
`ifndef ALU_XXX
`define ALU_XXX    4'hf
`endif

module tb_alu_md_sequencer;
  logic        clk = 1'b0;
  logic        reset, req_valid, kill;
  logic        req_ready, stall, resp_valid, alu_grant;
  logic [2:0]  req_funct3;
  logic [31:0] req_a, req_b, resp_data, alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_md_sequencer #(.XLEN(32), .ITERS(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_a(req_a), .req_b(req_b), .kill(kill),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
    .alu_grant(alu_grant), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out)
  );

  // shared stage-2 ALU stand-in
  always_comb begin
    alu_out = 32'h0;
    case (alu_op)
      `ALU_ADD:    alu_out = alu_a + alu_b;
      `ALU_SUB:    alu_out = alu_a - alu_b;
      `ALU_COPY_B: alu_out = alu_b;
      default:     alu_out = 32'h0;
    endcase
  end

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'h0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Issues one request and follows it to its response; bad counts bus/stall anomalies.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bad);
    bad = 0;
    lat = 0;
    @(negedge clk);
    if (!req_ready) bad++;
    req_valid = 1'b1; req_funct3 = f; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (!stall || !alu_grant) bad++;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!stall) bad++;
      if (resp_valid) break;
      if (!alu_grant || !(alu_op inside {`ALU_ADD, `ALU_SUB, `ALU_COPY_B})) bad++;
    end
    res = resp_data;
    if (alu_grant || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== `ALU_XXX) bad++;
    $display("op f3=%0d a=%h b=%h -> %h lat=%0d", f, a, b, res, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; kill = 1'b0;
    req_funct3 = 3'd0; req_a = 32'h0; req_b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, stall, resp_valid, alu_grant} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, stall, resp_valid, alu_grant});
    end
    checks++;
    if (resp_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", resp_data);
    end
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== `ALU_XXX) begin
      errors++; $display("FAIL reset_alu: got a=%h b=%h op=%h", alu_a, alu_b, alu_op);
    end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat, bad;
    run_op(3'd0, 32'd7, 32'hfffffffd, res, lat, bad);
    checks++;
    if (res !== 32'hffffffeb) begin errors++; $display("FAIL mul_val: got %h expected ffffffeb", res); end
    checks++;
    if (lat != 35) begin errors++; $display("FAIL mul_latency: got %0d expected 35", lat); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mul_bus: got %0d anomalies expected 0", bad); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mul_after: got valid=%b ready=%b stall=%b expected 0 1 0", resp_valid, req_ready, stall);
    end
  endtask

  // f3/a/b/expected vectors, each also with latency and bus checks
  task automatic test_vectors(input string name, input logic [2:0] f [4],
                              input logic [31:0] av [4], input logic [31:0] bv [4],
                              input logic [31:0] ev [4], input int n);
    logic [31:0] res;
    int lat, bad;
    for (int i = 0; i < n; i++) begin
      run_op(f[i], av[i], bv[i], res, lat, bad);
      checks++;
      if (res !== ev[i] || lat != 35 || bad != 0) begin
        errors++;
        $display("FAIL %s[%0d]: got %h lat=%0d bad=%0d expected %h lat=35 bad=0", name, i, res, lat, bad, ev[i]);
      end
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  f [4] = '{3'd1, 3'd3, 3'd2, 3'd0};
    logic [31:0] a [4] = '{32'h80000000, 32'hffffffff, 32'hffffffff, 32'h0};
    logic [31:0] b [4] = '{32'h80000000, 32'hffffffff, 32'd2, 32'h0};
    logic [31:0] e [4] = '{32'h40000000, 32'hfffffffe, 32'hffffffff, 32'h0};
    test_vectors("mulh", f, a, b, e, 3);
  endtask

  task automatic test_div();
    logic [2:0]  f [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] a [4] = '{32'hfffffff9, 32'hfffffff9, 32'd100, 32'd100};
    logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] e [4] = '{32'hfffffffd, 32'hffffffff, 32'd14, 32'd2};
    test_vectors("div", f, a, b, e, 4);
  endtask

  task automatic test_div_corner();
    logic [2:0]  f [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] a [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b [4] = '{32'h0, 32'h0, 32'hffffffff, 32'hffffffff};
    logic [31:0] e [4] = '{32'hffffffff, 32'd5, 32'h80000000, 32'h0};
    test_vectors("div_corner", f, a, b, e, 4);
  endtask

  task automatic test_kill();
    logic [31:0] prev, res;
    int lat, bad, stray;
    prev = resp_data;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd3; req_a = $urandom; req_b = $urandom | 32'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if (stall !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== prev) begin
      errors++;
      $display("FAIL kill_abort: got stall=%b ready=%b valid=%b data=%h expected 0 1 0 %h",
               stall, req_ready, resp_valid, resp_data, prev);
    end
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL kill_noresp: got %0d strobes expected 0", stray); end
    @(negedge clk);
    req_valid = 1'b1; kill = 1'b1; req_funct3 = 3'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL kill_idle: got stall=%b expected 0", stall); end
    run_op(3'd0, 32'd3, 32'd4, res, lat, bad);
    checks++;
    if (res !== 32'd12 || lat != 35) begin
      errors++; $display("FAIL kill_then_mul: got %h lat=%0d expected 0000000c lat=35", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd4; req_a = 32'd1000; req_b = 32'hfffffffd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({req_ready, stall, resp_valid, alu_grant} !== 4'b1000 || resp_data !== 32'h0 ||
        alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== `ALU_XXX) begin
      errors++;
      $display("FAIL reset_mid: got ctrl=%b data=%h op=%h expected 1000 00000000 f",
               {req_ready, stall, resp_valid, alu_grant}, resp_data, alu_op);
    end
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL reset_noresp: got %0d strobes expected 0", stray); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1;
    int lat, lat2;
    logic idle_ok, acc_ok;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    idle_ok = 1'b0; acc_ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd5; req_a = a1; req_b = b1;
    @(posedge clk);
    @(negedge clk);
    req_a = a2; req_b = b2;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (resp_valid) break;
    end
    r1 = resp_data;
    lat2 = 0;
    while (lat2 < 80) begin
      @(posedge clk); lat2++;
      @(negedge clk);
      if (lat2 == 1) idle_ok = req_ready && !stall;
      if (lat2 == 2) acc_ok = stall;
      if (resp_valid) break;
    end
    req_valid = 1'b0;
    $display("b2b a1=%h b1=%h -> %h ; a2=%h b2=%h -> %h gap=%0d", a1, b1, r1, a2, b2, resp_data, lat2);
    checks++;
    if (r1 !== ref_md(3'd5, a1, b1) || lat != 35) begin
      errors++; $display("FAIL b2b_first: got %h lat=%0d expected %h lat=35", r1, lat, ref_md(3'd5, a1, b1));
    end
    checks++;
    if (lat2 != 37 || !idle_ok || !acc_ok) begin
      errors++; $display("FAIL b2b_gap: got gap=%0d idle=%b acc=%b expected 37 1 1", lat2, idle_ok, acc_ok);
    end
    checks++;
    if (resp_data !== ref_md(3'd5, a2, b2)) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", resp_data, ref_md(3'd5, a2, b2));
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff};
    logic [31:0] a, b, res, exp;
    logic [2:0]  f;
    int lat, bad;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
      exp = ref_md(f, a, b);
      run_op(f, a, b, res, lat, bad);
      checks++;
      if (res !== exp || lat != 35 || bad != 0) begin
        errors++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: got %h lat=%0d bad=%0d expected %h",
                 i, f, a, b, res, lat, bad, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_corner();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
